// File: rtl/div_mae_monitor.sv
// Error monitor for the 16/8 array divider: recomputes the exact quotient/remainder
// with an 8-step restoring divider and accumulates MAE statistics. Optional macro: DIV_MAE_REM_EN.
module div_mae_monitor #(
    parameter int SUM_W = 32,
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      n,
    input  logic [7:0]       d,
    input  logic [7:0]       q_apx,
    input  logic [7:0]       r_apx,
    input  logic             clr,
    output logic             out_valid,
    output logic [7:0]       last_q_err,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [SUM_W-1:0] q_abs_sum,
    output logic [7:0]       q_max_err,
    output logic [SUM_W-1:0] r_abs_sum,
    output logic [1:0]       state_dbg
);

    // Handshake: a sample transfers on a rising edge where in_valid & in_ready are both high;
    // in_ready depends only on the FSM state, clr and rst, never on in_valid.

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] UPD  = 2'd2;

    logic [1:0] state;
    logic [2:0] step;
    logic [7:0] d_r;
    logic [7:0] lo_r;
    logic [7:0] qa_r;
    logic [7:0] part_r;
    logic [7:0] quo_r;

    logic             accept;
    logic             out_domain;
    logic [8:0]       shifted;
    logic [8:0]       diff9;
    logic             ge;
    logic [7:0]       part_next;
    logic [7:0]       eq;
    logic [SUM_W:0]   q_sum_wide;
    logic             rem_mis;
    logic             unused_bits;

    assign in_ready   = (state == IDLE) & ~clr & ~rst;
    assign accept     = in_valid & in_ready;
    assign out_domain = (d == 8'd0) || (n[15:8] >= d);
    assign state_dbg  = state;

    // Partial remainder is always < d before the shift, so 9 bits hold the shifted value.
    assign shifted   = {part_r, lo_r[7]};
    assign diff9     = shifted - {1'b0, d_r};
    assign ge        = (shifted >= {1'b0, d_r});
    assign part_next = ge ? diff9[7:0] : shifted[7:0];

    assign eq         = (quo_r >= qa_r) ? (quo_r - qa_r) : (qa_r - quo_r);
    assign q_sum_wide = {1'b0, q_abs_sum} + (SUM_W + 1)'(eq);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

`ifdef DIV_MAE_REM_EN
    logic [7:0]     ra_r;
    logic [7:0]     er;
    logic [SUM_W:0] r_sum_wide;

    assign er          = (part_r >= ra_r) ? (part_r - ra_r) : (ra_r - part_r);
    assign r_sum_wide  = {1'b0, r_abs_sum} + (SUM_W + 1)'(er);
    assign rem_mis     = (part_r != ra_r);
    assign unused_bits = diff9[8];
`else
    assign r_abs_sum   = '0;
    assign rem_mis     = 1'b0;
    assign unused_bits = ^{diff9[8], r_apx};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            step       <= '0;
            d_r        <= '0;
            lo_r       <= '0;
            qa_r       <= '0;
            part_r     <= '0;
            quo_r      <= '0;
            out_valid  <= 1'b0;
            last_q_err <= '0;
            sample_cnt <= '0;
            skip_cnt   <= '0;
            err_cnt    <= '0;
            q_abs_sum  <= '0;
            q_max_err  <= '0;
`ifdef DIV_MAE_REM_EN
            ra_r       <= '0;
            r_abs_sum  <= '0;
`endif
        end else if (clr) begin
            state      <= IDLE;
            step       <= '0;
            out_valid  <= 1'b0;
            last_q_err <= '0;
            sample_cnt <= '0;
            skip_cnt   <= '0;
            err_cnt    <= '0;
            q_abs_sum  <= '0;
            q_max_err  <= '0;
`ifdef DIV_MAE_REM_EN
            r_abs_sum  <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (out_domain) begin
                            skip_cnt <= sat_inc(skip_cnt);
                        end else begin
                            d_r    <= d;
                            lo_r   <= n[7:0];
                            part_r <= n[15:8];
                            qa_r   <= q_apx;
                            quo_r  <= '0;
                            step   <= '0;
                            state  <= DIV;
`ifdef DIV_MAE_REM_EN
                            ra_r   <= r_apx;
`endif
                        end
                    end
                end
                DIV: begin
                    part_r <= part_next;
                    lo_r   <= {lo_r[6:0], 1'b0};
                    quo_r  <= {quo_r[6:0], ge};
                    step   <= step + 3'd1;
                    if (step == 3'd7) state <= UPD;
                end
                UPD: begin
                    last_q_err <= eq;
                    q_abs_sum  <= q_sum_wide[SUM_W] ? '1 : q_sum_wide[SUM_W-1:0];
                    if (eq > q_max_err) q_max_err <= eq;
                    sample_cnt <= sat_inc(sample_cnt);
                    if ((quo_r != qa_r) || rem_mis) err_cnt <= sat_inc(err_cnt);
`ifdef DIV_MAE_REM_EN
                    r_abs_sum  <= r_sum_wide[SUM_W] ? '1 : r_sum_wide[SUM_W-1:0];
`endif
                    out_valid  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_mae_monitor.sv
// Directed bench for div_mae_monitor: a reference model pushes expected commit
// results into a queue, which is popped and compared when out_valid pulses.
module tb_div_mae_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] n;
    logic [7:0]  d;
    logic [7:0]  q_apx;
    logic [7:0]  r_apx;
    logic        clr;
    logic        out_valid;
    logic [7:0]  last_q_err;
    logic [23:0] sample_cnt;
    logic [23:0] skip_cnt;
    logic [23:0] err_cnt;
    logic [31:0] q_abs_sum;
    logic [7:0]  q_max_err;
    logic [31:0] r_abs_sum;
    logic [1:0]  state_dbg;

    div_mae_monitor #(.SUM_W(32), .CNT_W(24)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .n(n), .d(d), .q_apx(q_apx), .r_apx(r_apx), .clr(clr),
        .out_valid(out_valid), .last_q_err(last_q_err),
        .sample_cnt(sample_cnt), .skip_cnt(skip_cnt), .err_cnt(err_cnt),
        .q_abs_sum(q_abs_sum), .q_max_err(q_max_err), .r_abs_sum(r_abs_sum),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int miscompares = 0;

    // Reference model state
    int     m_sample = 0;
    int     m_skip = 0;
    int     m_err = 0;
    int     m_qmax = 0;
    longint m_qsum = 0;
    longint m_rsum = 0;
    logic [127:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic model_clear();
        m_sample = 0; m_skip = 0; m_err = 0; m_qmax = 0; m_qsum = 0; m_rsum = 0;
    endtask

    task automatic model(input logic [15:0] nn, input logic [7:0] dd,
                         input logic [7:0] qa, input logic [7:0] ra);
        int qe, re, eq, er;
        bit rem_bad;
        if (dd == 8'd0 || nn[15:8] >= dd) begin
            m_skip++;
        end else begin
            qe = int'(nn) / int'(dd);
            re = int'(nn) % int'(dd);
            eq = (qe >= int'(qa)) ? qe - int'(qa) : int'(qa) - qe;
            er = (re >= int'(ra)) ? re - int'(ra) : int'(ra) - re;
            rem_bad = 1'b0;
`ifdef DIV_MAE_REM_EN
            rem_bad = (re != int'(ra));
            m_rsum = m_rsum + er;
            if (m_rsum > 64'hFFFF_FFFF) m_rsum = 64'hFFFF_FFFF;
`endif
            m_sample++;
            if (qe != int'(qa) || rem_bad) m_err++;
            m_qsum = m_qsum + eq;
            if (m_qsum > 64'hFFFF_FFFF) m_qsum = 64'hFFFF_FFFF;
            if (eq > m_qmax) m_qmax = eq;
            exp_q.push_back({8'(eq), 24'(m_sample), 24'(m_err), 32'(m_qsum),
                             8'(m_qmax), 32'(m_rsum)});
        end
    endtask

    // Called at a negedge: drive one sample across the next rising edge.
    task automatic drive_now(input logic [15:0] nn, input logic [7:0] dd,
                             input logic [7:0] qa, input logic [7:0] ra, input bit do_model);
        n = nn; d = dd; q_apx = qa; r_apx = ra; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (do_model) model(nn, dd, qa, ra);
    endtask

    task automatic send(input logic [15:0] nn, input logic [7:0] dd,
                        input logic [7:0] qa, input logic [7:0] ra, input bit do_model);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_before_send", 32'(in_ready), 32'd1);
        drive_now(nn, dd, qa, ra, do_model);
    endtask

    // Waits for out_valid (expected 10 negedges after the accepting edge).
    task automatic wait_out(input string tag);
        int k = 0;
        bit seen = 1'b0;
        logic [127:0] e = '0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (out_valid) seen = 1'b1;
        end
        check({tag, "_latency"}, seen ? 32'(k) : 32'd0, 32'd10);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check({tag, "_last_q_err"}, 32'(last_q_err), 32'(e[127:120]));
        check({tag, "_sample_cnt"}, 32'(sample_cnt), 32'(e[119:96]));
        check({tag, "_err_cnt"},    32'(err_cnt),    32'(e[95:72]));
        check({tag, "_q_abs_sum"},  q_abs_sum,       e[71:40]);
        check({tag, "_q_max_err"},  32'(q_max_err),  32'(e[39:32]));
        check({tag, "_r_abs_sum"},  r_abs_sum,       e[31:0]);
        check({tag, "_skip_cnt"},   32'(skip_cnt),   32'(m_skip));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"},  32'(out_valid),  32'd0);
        check({tag, "_sample_cnt"}, 32'(sample_cnt), 32'd0);
        check({tag, "_skip_cnt"},   32'(skip_cnt),   32'd0);
        check({tag, "_err_cnt"},    32'(err_cnt),    32'd0);
        check({tag, "_q_abs_sum"},  q_abs_sum,       32'd0);
        check({tag, "_q_max_err"},  32'(q_max_err),  32'd0);
        check({tag, "_last_q_err"}, 32'(last_q_err), 32'd0);
        check({tag, "_r_abs_sum"},  r_abs_sum,       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  rd, rhi, rlo, rq, rr;
        bit          ov_seen;

        // Reset
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0;
        n = '0; d = '0; q_apx = '0; r_apx = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        check("reset_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", 32'(in_ready), 32'd1);

        // 100/7 = 14 r 2, approximate quotient 12
        send(16'd100, 8'd7, 8'd12, 8'd2, 1'b1);
        wait_out("basic");

        // Back-to-back out-of-domain samples
        send(16'h0800, 8'd8, 8'd0, 8'd0, 1'b1);
        check("skip2_in_ready", 32'(in_ready), 32'd1);
        drive_now(16'h1234, 8'd0, 8'd0, 8'd0, 1'b1);
        ov_seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            ov_seen |= out_valid;
        end
        check("skip_no_out_valid", 32'(ov_seen), 32'd0);
        check("skip_cnt", 32'(skip_cnt), 32'(m_skip));
        check("skip_sample_cnt", 32'(sample_cnt), 32'(m_sample));

        // Exact result at the domain edge: 65000/255 = 254 r 230
        send(16'd65000, 8'd255, 8'd254, 8'd230, 1'b1);
        wait_out("exact");

        // Random in-domain samples
        repeat (4) begin
            rd  = 8'($urandom_range(1, 255));
            rhi = 8'($urandom_range(0, int'(rd) - 1));
            rlo = 8'($urandom_range(0, 255));
            rq  = 8'($urandom_range(0, 255));
            rr  = 8'($urandom_range(0, 255));
            send({rhi, rlo}, rd, rq, rr, 1'b1);
            wait_out("random");
        end

        // Saturation of q_abs_sum: preload all-ones minus one, then eq = 5
        @(negedge clk);
        force dut.q_abs_sum = 32'hFFFF_FFFE;
        @(posedge clk);
        #1 release dut.q_abs_sum;
        m_qsum = 64'hFFFF_FFFE;
        send(16'd100, 8'd7, 8'd9, 8'd2, 1'b1);
        wait_out("saturate");

        // clr blocks a sample offered in the same cycle and clears statistics
        @(negedge clk);
        clr = 1'b1;
        n = 16'h1234; d = 8'd0; in_valid = 1'b1;
        #1 check("clr_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 clr = 1'b0; in_valid = 1'b0;
        model_clear();
        @(negedge clk);
        check_all_zero("clr_offer");

        // Abort an in-flight sample with clr at T+4, then accept a new one at T+5
        send(16'd200, 8'd9, 8'd1, 8'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        check("abort_in_ready", 32'(in_ready), 32'd1);
        drive_now(16'd500, 8'd20, 8'd25, 8'd0, 1'b1);
        wait_out("after_abort");

        // Asynchronous reset during DIV
        send(16'd300, 8'd11, 8'd0, 8'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        check("async_rst_in_ready", 32'(in_ready), 32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        send(16'd1000, 8'd30, 8'd30, 8'd10, 1'b1);
        wait_out("after_rst");

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
